// File: rtl/rv_mem_arbiter_if.sv
// Single-ported memory bus between the arbiter (master)
// and the memory/interconnect (slave).
interface rv_mem_arbiter_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr,
    output bus_wdata, bus_wmask,
    input  bus_rdata, bus_ack, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr,
    input  bus_wdata, bus_wmask,
    output bus_rdata, bus_ack, bus_err
  );
endinterface

// File: rtl/rv_mem_arbiter.sv
// Fetch/load-store arbiter onto one memory bus: data priority,
// bounded fetch starvation, one outstanding txn, bus timeout.
module rv_mem_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_err,
  output logic        d_stall,
  rv_mem_arbiter_if.master bus
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] LP_SMAX = SW'(MAX_D_STREAK);
  localparam bit LP_TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LP_TO_LAST =
    LP_TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE, BUSY_I, BUSY_D, RESP
  } state_t;

  state_t      r_state;
  logic [SW-1:0]    r_streak;
  logic [CNT_W-1:0] r_cnt;

  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_wmask;

  logic [31:0] r_i_rdata;
  logic        r_i_valid;
  logic        r_i_err;
  logic [31:0] r_d_rdata;
  logic        r_d_valid;
  logic        r_d_err;

  logic        w_grant_d;
  logic        w_grant_i;
  logic        w_abort;
  logic        w_done;
  logic [31:0] w_rsp_data;
  logic        w_rsp_err;

  assign w_grant_d = d_req & (~i_req | (r_streak < LP_SMAX));
  assign w_grant_i = i_req & ~w_grant_d;

  assign w_abort = LP_TO_EN && (r_cnt == LP_TO_LAST);
  assign w_done  = bus.bus_ack | w_abort;

  // Ack wins over a simultaneous timeout.
  assign w_rsp_data = bus.bus_ack ? bus.bus_rdata : 32'h0;
  assign w_rsp_err  = bus.bus_ack ? bus.bus_err   : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_streak    <= '0;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_wdata <= 32'h0;
      r_bus_wmask <= 4'b0;
      r_i_rdata   <= 32'h0;
      r_i_valid   <= 1'b0;
      r_i_err     <= 1'b0;
      r_d_rdata   <= 32'h0;
      r_d_valid   <= 1'b0;
      r_d_err     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          unique case (1'b1)
            w_grant_d: begin
              r_state     <= BUSY_D;
              r_bus_req   <= 1'b1;
              r_bus_we    <= d_we;
              r_bus_addr  <= d_addr;
              r_bus_wdata <= d_wdata;
              r_bus_wmask <= d_we ? d_wmask : 4'b0;
              if (!i_req)
                r_streak <= '0;
              else if (r_streak != LP_SMAX)
                r_streak <= r_streak + 1'b1;
            end
            w_grant_i: begin
              r_state     <= BUSY_I;
              r_bus_req   <= 1'b1;
              r_bus_we    <= 1'b0;
              r_bus_addr  <= i_addr;
              r_bus_wdata <= 32'h0;
              r_bus_wmask <= 4'b0;
              r_streak    <= '0;
            end
            default: ;
          endcase
        end
        BUSY_I, BUSY_D: begin
          if (w_done) begin
            r_state   <= RESP;
            r_bus_req <= 1'b0;
            if (r_state == BUSY_D) begin
              r_d_valid <= 1'b1;
              r_d_rdata <= w_rsp_data;
              r_d_err   <= w_rsp_err;
            end else begin
              r_i_valid <= 1'b1;
              r_i_rdata <= w_rsp_data;
              r_i_err   <= w_rsp_err;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_state   <= IDLE;
          r_i_valid <= 1'b0;
          r_i_err   <= 1'b0;
          r_d_valid <= 1'b0;
          r_d_err   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;
  assign bus.bus_wmask = r_bus_wmask;

  assign i_rdata = r_i_rdata;
  assign i_valid = r_i_valid;
  assign i_err   = r_i_err;
  assign d_rdata = r_d_rdata;
  assign d_valid = r_d_valid;
  assign d_err   = r_d_err;
  assign d_stall = d_req & ~r_d_valid;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter: scoreboard of expected
// responses checked as valids appear, plus bus/timing checks.
module tb_rv_mem_arbiter;
  localparam logic [31:0] K = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_err;
  logic        d_stall;

  rv_mem_arbiter_if bus();

  rv_mem_arbiter #(
    .MAX_D_STREAK(4),
    .TIMEOUT(64),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_rdata(i_rdata),
    .i_valid(i_valid),
    .i_err(i_err),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_wmask(d_wmask),
    .d_rdata(d_rdata),
    .d_valid(d_valid),
    .d_err(d_err),
    .d_stall(d_stall),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  // Memory model
  int          lat = 1;
  bit          hang = 0;
  bit          use_xor = 0;
  logic [31:0] rsp_data = 32'h0;
  logic        rsp_err = 1'b0;
  int          bcnt = 0;

  always @(negedge clk) begin
    if (bus.bus_req === 1'b1) begin
      bcnt = bcnt + 1;
      bus.bus_ack = !hang && (bcnt == lat);
    end else begin
      bcnt = 0;
      bus.bus_ack = 1'b0;
    end
    bus.bus_rdata = use_xor ? (bus.bus_addr ^ K) : rsp_data;
    bus.bus_err = rsp_err;
  end

  // Response monitor
  always @(negedge clk) begin
    if (reset === 1'b0 && (i_valid === 1'b1 || d_valid === 1'b1)) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected i_valid=%0b d_valid=%0b", i_valid, d_valid);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        assert ({d_valid, i_valid} === (e.is_d ? 2'b10 : 2'b01)) else begin
          errors++;
          $error("FAIL sb_port got d/i=%b%b want is_d=%0b", d_valid, i_valid, e.is_d);
        end
        checks++;
        assert ((e.is_d ? d_rdata : i_rdata) === e.rd) else begin
          errors++;
          $error("FAIL sb_rdata got %h/%h want %h", d_rdata, i_rdata, e.rd);
        end
        checks++;
        assert ({d_err, i_err} === (e.is_d ? {e.err, 1'b0} : {1'b0, e.err})) else begin
          errors++;
          $error("FAIL sb_err got d/i=%b%b want %b is_d=%0b", d_err, i_err, e.err, e.is_d);
        end
      end
    end
  end

  task automatic do_txn(
    input string       tag,
    input bit          is_d,
    input bit          we,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [3:0]  wm,
    input logic [31:0] exp_rd,
    input logic        exp_err,
    output int         nreq,
    output int         nlat
  );
    bit ok;
    bit done;
    logic [3:0] exp_wm;
    exp_wm = (is_d && we) ? wm : 4'b0;
    nreq = 0;
    nlat = 0;
    ok = 1;
    done = 0;
    sb.push_back(exp_t'{is_d, exp_rd, exp_err});
    if (is_d) begin
      d_req = 1; d_we = we; d_addr = addr;
      d_wdata = wd; d_wmask = wm;
    end else begin
      i_req = 1; i_addr = addr;
    end
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk); #1;
      nlat++;
      if (bus.bus_req === 1'b1) begin
        nreq++;
        if (bus.bus_addr !== addr) ok = 0;
        if (bus.bus_we !== (is_d && we)) ok = 0;
        if (bus.bus_wmask !== exp_wm) ok = 0;
        if (is_d && we && bus.bus_wdata !== wd) ok = 0;
      end
      if ((is_d ? i_valid : d_valid) !== 1'b0) ok = 0;
      if ((is_d ? d_valid : i_valid) === 1'b1) done = 1;
      else if (is_d && d_stall !== 1'b1) ok = 0;
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL %s_timeout got no valid want valid", tag);
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s_bus got bad bus/stall/port want stable", tag);
    end
    if (is_d && done) begin
      checks++;
      assert (d_stall === 1'b0) else begin
        errors++;
        $error("FAIL %s_stall_valid got %b want 0", tag, d_stall);
      end
    end
    d_req = 0;
    i_req = 0;
  endtask

  int nreq;
  int nlat;
  int nv;

  initial begin
    reset = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_wdata = 0; d_wmask = 0;
    @(negedge clk); #1;
    checks++;
    assert ({bus.bus_req, bus.bus_we, bus.bus_wmask, i_valid, d_valid,
             i_err, d_err, d_stall} === 11'b0) else begin
      errors++;
      $error("FAIL reset_ctl got %b want 0", {bus.bus_req, bus.bus_we,
             bus.bus_wmask, i_valid, d_valid, i_err, d_err, d_stall});
    end
    checks++;
    assert ({i_rdata, d_rdata, bus.bus_addr} === 96'h0) else begin
      errors++;
      $error("FAIL reset_data got %h %h %h want 0", i_rdata, d_rdata, bus.bus_addr);
    end
    @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);

    // Single load, 3-cycle ack
    lat = 3; rsp_data = 32'hDEADBEEF; rsp_err = 0;
    do_txn("load", 1, 0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 0, nreq, nlat);
    checks++;
    assert (nreq === 3) else begin
      errors++; $error("FAIL load_req_cycles got %0d want 3", nreq);
    end
    checks++;
    assert (nlat === 4) else begin
      errors++; $error("FAIL load_latency got %0d want 4", nlat);
    end
    @(negedge clk);

    // Store with partial mask
    lat = 2; rsp_data = 32'hCAFE0001;
    do_txn("store", 1, 1, 32'h104, 32'h12345678, 4'b0011,
           32'hCAFE0001, 0, nreq, nlat);
    checks++;
    assert (nreq === 2) else begin
      errors++; $error("FAIL store_req_cycles got %0d want 2", nreq);
    end
    @(negedge clk);

    // Fetch with bus error, then a clean fetch
    lat = 1; rsp_data = 32'h0BAD0BAD; rsp_err = 1;
    do_txn("ifetch_err", 0, 0, 32'h200, 32'h0, 4'h0,
           32'h0BAD0BAD, 1, nreq, nlat);
    checks++;
    assert (nlat === 2) else begin
      errors++; $error("FAIL ifetch_min_latency got %0d want 2", nlat);
    end
    rsp_data = 32'h00C0FFEE; rsp_err = 0;
    do_txn("ifetch_ok", 0, 0, 32'h204, 32'h0, 4'h0,
           32'h00C0FFEE, 0, nreq, nlat);
    @(negedge clk);

    // Both held: fetch forced through after 4 data grants
    lat = 1; use_xor = 1;
    for (int k = 0; k < 10; k++) begin
      if ((k % 5) == 4) sb.push_back(exp_t'{1'b0, 32'h500 ^ K, 1'b0});
      else sb.push_back(exp_t'{1'b1, 32'h400 ^ K, 1'b0});
    end
    d_req = 1; d_we = 0; d_addr = 32'h400; i_req = 1; i_addr = 32'h500;
    for (int c = 0; c < 300 && sb.size() != 0; c++) begin
      @(negedge clk); #1;
    end
    d_req = 0; i_req = 0;
    checks++;
    assert (sb.size() == 0) else begin
      errors++; $error("FAIL arb_drain got %0d left want 0", sb.size());
    end
    @(negedge clk);

    // Hung bus: timeout abort, then normal follow-up fetch
    use_xor = 0; hang = 1;
    do_txn("timeout", 1, 0, 32'h300, 32'h0, 4'h0, 32'h0, 1, nreq, nlat);
    checks++;
    assert (nreq === 64) else begin
      errors++; $error("FAIL timeout_req_cycles got %0d want 64", nreq);
    end
    hang = 0; rsp_data = 32'h7777_1234;
    do_txn("after_to", 0, 0, 32'h240, 32'h0, 4'h0,
           32'h7777_1234, 0, nreq, nlat);
    @(negedge clk);

    // Reset mid BUSY_D
    hang = 1;
    d_req = 1; d_we = 0; d_addr = 32'h600; i_req = 1; i_addr = 32'h700;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    assert (bus.bus_req === 1'b1) else begin
      errors++; $error("FAIL rst_pre_busy got %b want 1", bus.bus_req);
    end
    reset = 1;
    #1;
    checks++;
    assert ({bus.bus_req, bus.bus_we, bus.bus_wmask, i_valid, d_valid,
             i_err, d_err} === 10'b0) else begin
      errors++; $error("FAIL rst_mid_ctl got %b want 0", {bus.bus_req,
             bus.bus_we, bus.bus_wmask, i_valid, d_valid, i_err, d_err});
    end
    checks++;
    assert ({i_rdata, d_rdata, bus.bus_addr} === 96'h0) else begin
      errors++;
      $error("FAIL rst_mid_data got %h %h %h want 0", i_rdata, d_rdata, bus.bus_addr);
    end
    d_req = 0; i_req = 0; hang = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    nv = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (d_valid !== 1'b0 || i_valid !== 1'b0 || bus.bus_req !== 1'b0) nv++;
    end
    checks++;
    assert (nv == 0) else begin
      errors++; $error("FAIL rst_stale got %0d bad cycles want 0", nv);
    end

    // Streak must restart from 0: D,D,D,D,I
    use_xor = 1; lat = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) sb.push_back(exp_t'{1'b0, 32'h700 ^ K, 1'b0});
      else sb.push_back(exp_t'{1'b1, 32'h600 ^ K, 1'b0});
    end
    d_req = 1; d_addr = 32'h600; i_req = 1; i_addr = 32'h700;
    for (int c = 0; c < 200 && sb.size() != 0; c++) begin
      @(negedge clk); #1;
    end
    d_req = 0; i_req = 0;
    checks++;
    assert (sb.size() == 0) else begin
      errors++; $error("FAIL rst_arb_drain got %0d left want 0", sb.size());
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory bus between the RV32I core's instruction-fetch port and load/store port.
- Sits between the core and the memory/interconnect.
- Fixed priority: data wins over fetch. A starvation counter bounds how long fetch can be locked out.
- At most one transaction is outstanding at a time. A per-transaction timeout converts a hung bus into an error response.

Parameters:
MAX_D_STREAK, 4, consecutive D grants allowed while i_req is pending before I is forced through (must be >=1)
TIMEOUT, 64, bus cycles to wait for bus_ack before aborting with error; 0 disables the timeout
CNT_W, 8, width of the timeout counter (2**CNT_W > TIMEOUT)

Ports:
clk  in  1  clock
reset  in  1  reset (see Behaviour)
i_req  in  1  fetch request; held with i_addr stable until i_valid
i_addr  in  32  fetch word address
i_rdata  out  32  fetch data, valid with i_valid
i_valid  out  1  one-cycle fetch completion pulse
i_err  out  1  fetch access fault, qualified by i_valid
d_req  in  1  load/store request; held with d_* stable until d_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data address
d_wdata  in  32  store data
d_wmask  in  4  byte write mask
d_rdata  out  32  load data, valid with d_valid
d_valid  out  1  one-cycle data completion pulse
d_err  out  1  data bus error, qualified by d_valid
d_stall  out  1  combinational d_req & ~d_valid; drives the core data_stall
bus_req  out  1  bus request, held until ack or abort
bus_we  out  1  bus write enable
bus_addr  out  32  bus address
bus_wdata  out  32  bus write data
bus_wmask  out  4  bus byte mask; 4'b0000 on every read
bus_rdata  in  32  read data, sampled with bus_ack
bus_ack  in  1  transaction complete
bus_err  in  1  error, sampled only with bus_ack

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk.
  - All outputs and internal registers go to 0, state goes to IDLE. This includes bus_req, which drops immediately.
  - A transaction in flight at reset is abandoned with no response.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, arbitration:
  - Grant D if d_req and (~i_req or streak < MAX_D_STREAK).
  - Otherwise grant I if i_req.
  - On grant, latch the address/we/wdata/wmask of the winner into the bus registers and move to BUSY_x. Nothing is driven combinationally from requester inputs.
  - For I grants, bus_we=0 and bus_wmask=0.
- streak counter:
  - On a D grant with i_req high: streak += 1, saturating.
  - On a D grant with i_req low: streak = 0.
  - On any I grant: streak = 0.
- BUSY_x:
  - bus_req=1 and bus_* stable for the whole state.
  - bus_ack: capture bus_rdata and bus_err, go to RESP.
  - Timeout: a counter increments each BUSY cycle without ack. If TIMEOUT!=0 and the count reaches TIMEOUT-1 with no ack, abort: bus_req drops, go to RESP with err=1 and rdata=0.
  - A bus_ack arriving in the abort cycle takes precedence (normal completion).
- RESP (exactly 1 cycle):
  - Assert x_valid plus x_rdata/x_err for the owner. Outputs of the other port stay 0.
  - d_rdata and i_rdata hold their last value otherwise; only the valid/err flags are pulsed.
  - No arbitration happens in RESP. Next state is IDLE.
- Latency: request seen in IDLE at cycle t → bus_req at t+1 → ack at t+k (k>=1) → valid at t+k+1 → IDLE at t+k+2. Minimum is 2 cycles to valid, back-to-back throughput is 1 transaction per 3 cycles.
- Simultaneous d_req and i_req in IDLE: D wins unless streak == MAX_D_STREAK.
- A requester that drops req before its valid is a protocol violation. The transaction still completes and the response is delivered unconditionally.
- bus_err without bus_ack is ignored.
- bus_ack in IDLE or RESP is ignored.

Test Plan:
- Single load, d_addr=0x100, memory returns 0xDEADBEEF after 3 cycles → bus_req high for exactly 3 cycles, d_valid one cycle later with d_rdata=0xDEADBEEF and d_err=0; d_stall high from request until the d_valid cycle.
- Store, d_wdata=0x12345678, d_wmask=4'b0011 → bus_we=1 and bus_wmask=0011 stable until ack; i_valid never asserts.
- i_req and d_req held high continuously, MAX_D_STREAK=4, ack latency 1 → grant order D,D,D,D,I,D,D,D,D,I…; fetch waits at most 4 D transactions.
- bus_ack withheld, TIMEOUT=64 → bus_req drops after 64 BUSY cycles, then x_valid=1, x_err=1, x_rdata=0; a following request is granted normally.
- Fetch at 0x200 acked with bus_err=1 → i_valid=1, i_err=1; a later fetch acked clean → i_err=0.
- reset asserted mid BUSY_D → bus_req and all outputs 0 immediately; after release the FSM is in IDLE, streak=0, and no stale d_valid appears.
